// File: rtl/fb_pkg.sv
// Shared constants, colours and FSM encoding for the frame-buffer rectangle painter.
package fb_pkg;

    localparam int unsigned SCREEN_X = 176;
    localparam int unsigned SCREEN_Y = 120;
    localparam int unsigned AW       = 15;
    localparam int unsigned DW       = 3;

    localparam int unsigned MAX_ADDR = SCREEN_X * SCREEN_Y - 1;

    // RGB 111: bit2 R, bit1 G, bit0 B
    localparam logic [DW-1:0] RED   = 3'b100;
    localparam logic [DW-1:0] GREEN = 3'b010;
    localparam logic [DW-1:0] BLUE  = 3'b001;
    localparam logic [DW-1:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StWrite,
        StDone
    } fb_state_e;

    // 176 = 128 + 32 + 16, so the row base needs only three shifted adds.
    function automatic logic [AW-1:0] row_base_of(input logic [6:0] y);
        return AW'({y, 7'b0}) + AW'({y, 5'b0}) + AW'({y, 4'b0});
    endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Request handshake plus frame-buffer write port of the rectangle painter.
interface fb_rect_writer_if;
    import fb_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_x;
    logic [6:0]    req_y;
    logic [7:0]    req_w;
    logic [6:0]    req_h;
    logic [DW-1:0] req_color;

    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic          busy;
    logic          done;

    modport master (
        output req_valid, req_x, req_y, req_w, req_h, req_color,
        input  req_ready, mem_px_addr, mem_px_data, px_wr, busy, done
    );

    modport slave (
        input  req_valid, req_x, req_y, req_w, req_h, req_color,
        output req_ready, mem_px_addr, mem_px_data, px_wr, busy, done
    );

endinterface

// File: rtl/fb_rect_clip.sv
// Clips a latched rectangle to the playfield; exclusive end coordinates plus empty flag.
module fb_rect_clip
    import fb_pkg::*;
(
    input  logic [7:0] x_i,
    input  logic [6:0] y_i,
    input  logic [7:0] w_i,
    input  logic [6:0] h_i,
    output logic [7:0] x_end_o,
    output logic [6:0] y_end_o,
    output logic       zero_area_o
);

    logic [8:0] x_sum;
    logic [7:0] y_sum;

    always_comb begin
        // Widened sums so an oversize w/h cannot wrap back into the screen.
        x_sum = {1'b0, x_i} + {1'b0, w_i};
        y_sum = {1'b0, y_i} + {1'b0, h_i};

        x_end_o = (x_sum > 9'(SCREEN_X)) ? 8'(SCREEN_X) : x_sum[7:0];
        y_end_o = (y_sum > 8'(SCREEN_Y)) ? 7'(SCREEN_Y) : y_sum[6:0];

        zero_area_o = (w_i == 8'd0) || (h_i == 7'd0) ||
                      ({1'b0, x_i} >= 9'(SCREEN_X)) ||
                      ({1'b0, y_i} >= 8'(SCREEN_Y));
    end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle painter: latches a request, clips it, then streams one pixel write per clock.
module fb_rect_writer
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fb_rect_writer_if.slave  bus
);

    fb_state_e     state_q;
    logic [7:0]    x_q;
    logic [6:0]    y_q;
    logic [7:0]    w_q;
    logic [6:0]    h_q;
    logic [DW-1:0] color_q;

    logic [7:0]    x_last_q;
    logic [6:0]    y_last_q;
    logic [7:0]    col_q;
    logic [6:0]    row_q;
    logic [AW-1:0] row_base_q;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          wr_q;
    logic          done_q;
    logic          busy_q;
    logic          ready_q;

    logic [7:0]    x_end;
    logic [6:0]    y_end;
    logic          zero_area;

    logic [AW-1:0] row_base_d;
    logic [AW-1:0] next_row_base;
    logic [7:0]    col_d;
    logic [6:0]    row_d;

    fb_rect_clip u_clip (
        .x_i        (x_q),
        .y_i        (y_q),
        .w_i        (w_q),
        .h_i        (h_q),
        .x_end_o    (x_end),
        .y_end_o    (y_end),
        .zero_area_o(zero_area)
    );

    always_comb begin
        row_base_d    = row_base_of(y_q);
        next_row_base = row_base_q + AW'(SCREEN_X);
        col_d         = col_q + 8'd1;
        row_d         = row_q + 7'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            x_last_q   <= '0;
            y_last_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        x_q     <= bus.req_x;
                        y_q     <= bus.req_y;
                        w_q     <= bus.req_w;
                        h_q     <= bus.req_h;
                        color_q <= bus.req_color;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (zero_area) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        // First pixel is emitted here so writes start the cycle after setup.
                        x_last_q   <= x_end - 8'd1;
                        y_last_q   <= y_end - 7'd1;
                        col_q      <= x_q;
                        row_q      <= y_q;
                        row_base_q <= row_base_d;
                        addr_q     <= row_base_d + AW'(x_q);
                        data_q     <= color_q;
                        wr_q       <= 1'b1;
                        state_q    <= StWrite;
                    end
                end
                StWrite: begin
                    if (col_q == x_last_q) begin
                        if (row_q == y_last_q) begin
                            wr_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            col_q      <= x_q;
                            row_q      <= row_d;
                            row_base_q <= next_row_base;
                            addr_q     <= next_row_base + AW'(x_q);
                        end
                    end else begin
                        col_q  <= col_d;
                        addr_q <= row_base_q + AW'(col_d);
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.px_wr       = wr_q;
    assign bus.mem_px_addr = addr_q;
    assign bus.mem_px_data = data_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer: per-scenario tasks with hand-computed expectations.
module tb_fb_rect_writer;
    import fb_pkg::*;

    logic clk;
    logic rst;

    fb_rect_writer_if bus ();

    fb_rect_writer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [AW-1:0] wr_addr [0:127];
    logic [DW-1:0] wr_data [0:127];
    int            wr_cyc  [0:127];
    int            nwr;
    int            done_at;
    int            ready_at;
    int            done_cnt;
    logic          s_ready;
    logic          s_busy;
    logic          s_wr;

    // Issues one request from a negedge, scrambles the request fields after acceptance,
    // then records the write stream relative to the handshake edge (cycle k = N+k).
    task automatic run_rect(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                            input logic [6:0] h, input logic [2:0] c, input int max_cyc);
        nwr      = 0;
        done_at  = -1;
        ready_at = -1;
        done_cnt = 0;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_w     = w;
        bus.req_h     = h;
        bus.req_color = c;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_x     = ~x;
        bus.req_y     = ~y;
        bus.req_w     = 8'd200;
        bus.req_h     = 7'd100;
        bus.req_color = ~c;
        for (int k = 1; k <= max_cyc && ready_at < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                s_ready = bus.req_ready;
                s_busy  = bus.busy;
                s_wr    = bus.px_wr;
            end
            if (bus.px_wr === 1'b1 && nwr < 128) begin
                wr_addr[nwr] = bus.mem_px_addr;
                wr_data[nwr] = bus.mem_px_data;
                wr_cyc[nwr]  = k;
                nwr++;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (bus.req_ready === 1'b1 && done_at >= 0) ready_at = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.px_wr, bus.done, bus.busy, bus.req_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_ctrl wr/done/busy/ready got %b want 0001",
                     {bus.px_wr, bus.done, bus.busy, bus.req_ready});
        end
        vectors++;
        if (bus.mem_px_addr !== 15'd0 || bus.mem_px_data !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_mem addr=%0d data=%b want 0/000", bus.mem_px_addr, bus.mem_px_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [AW-1:0] exp_a [0:5];
        exp_a[0] = 15'd890;  exp_a[1] = 15'd891;  exp_a[2] = 15'd892;
        exp_a[3] = 15'd1066; exp_a[4] = 15'd1067; exp_a[5] = 15'd1068;
        run_rect(8'd10, 7'd5, 8'd3, 7'd2, RED, 40);
        vectors++;
        if ({s_ready, s_busy, s_wr} !== 3'b010) begin
            miscompares++;
            $display("FAIL basic_setup ready/busy/wr got %b want 010", {s_ready, s_busy, s_wr});
        end
        vectors++;
        if (nwr != 6) begin
            miscompares++;
            $display("FAIL basic_count writes=%0d want 6", nwr);
        end
        for (int i = 0; i < 6 && i < nwr; i++) begin
            vectors++;
            if (wr_addr[i] !== exp_a[i] || wr_data[i] !== RED || wr_cyc[i] != i + 2) begin
                miscompares++;
                $display("FAIL basic_px%0d addr=%0d data=%b cyc=%0d want %0d/%b/%0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i], exp_a[i], RED, i + 2);
            end
        end
        vectors++;
        if (done_at != 8 || done_cnt != 1 || ready_at != 9) begin
            miscompares++;
            $display("FAIL basic_done done_at=%0d pulses=%0d ready_at=%0d want 8/1/9",
                     done_at, done_cnt, ready_at);
        end
    endtask

    task automatic test_clip();
        logic [AW-1:0] exp_a [0:3];
        exp_a[0] = 15'd20942; exp_a[1] = 15'd20943;
        exp_a[2] = 15'd21118; exp_a[3] = 15'd21119;
        run_rect(8'd174, 7'd118, 8'd5, 7'd5, GREEN, 40);
        vectors++;
        if (nwr != 4) begin
            miscompares++;
            $display("FAIL clip_count writes=%0d want 4", nwr);
        end
        for (int i = 0; i < 4 && i < nwr; i++) begin
            vectors++;
            if (wr_addr[i] !== exp_a[i] || wr_data[i] !== GREEN || wr_cyc[i] != i + 2) begin
                miscompares++;
                $display("FAIL clip_px%0d addr=%0d data=%b cyc=%0d want %0d/%b/%0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i], exp_a[i], GREEN, i + 2);
            end
        end
        vectors++;
        if (done_at != 6 || ready_at != 7) begin
            miscompares++;
            $display("FAIL clip_done done_at=%0d ready_at=%0d want 6/7", done_at, ready_at);
        end
    endtask

    task automatic test_zero_area();
        logic [7:0] zx [0:2];
        logic [6:0] zy [0:2];
        logic [7:0] zw [0:2];
        zx[0] = 8'd10;  zy[0] = 7'd10;  zw[0] = 8'd0;
        zx[1] = 8'd176; zy[1] = 7'd10;  zw[1] = 8'd5;
        zx[2] = 8'd0;   zy[2] = 7'd120; zw[2] = 8'd5;
        for (int v = 0; v < 3; v++) begin
            run_rect(zx[v], zy[v], zw[v], 7'd5, BLUE, 20);
            vectors++;
            if (nwr != 0 || done_at != 2 || ready_at != 3) begin
                miscompares++;
                $display("FAIL zero%0d writes=%0d done_at=%0d ready_at=%0d want 0/2/3",
                         v, nwr, done_at, ready_at);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int late_done;
        bit reached;
        seen    = 0;
        reached = 0;
        bus.req_x     = 8'd0;
        bus.req_y     = 7'd0;
        bus.req_w     = 8'd10;
        bus.req_h     = 7'd10;
        bus.req_color = BLUE;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 20 && !reached; k++) begin
            @(negedge clk);
            if (bus.px_wr === 1'b1) seen++;
            if (seen == 3) reached = 1;
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL rstmid_start writes=%0d want 3 before timeout", seen);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.px_wr !== 1'b0 || bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_drop wr=%b done=%b ready=%b want 0/0/1",
                     bus.px_wr, bus.done, bus.req_ready);
        end
        rst = 1'b1;
        late_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.px_wr === 1'b1) late_done++;
        end
        vectors++;
        if (late_done != 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet stray done/wr cycles=%0d want 0", late_done);
        end
        run_rect(8'd20, 7'd30, 8'd1, 7'd1, RED, 20);
        vectors++;
        if (nwr != 1 || wr_addr[0] !== 15'd5300 || wr_data[0] !== RED || done_at != 3) begin
            miscompares++;
            $display("FAIL rstmid_after writes=%0d addr=%0d data=%b done_at=%0d want 1/5300/100/3",
                     nwr, wr_addr[0], wr_data[0], done_at);
        end
    endtask

    task automatic test_back_to_back();
        int  b_acc;
        int  ready_hi_a;
        int  ndone;
        int  done_k [0:1];
        logic [AW-1:0] exp_a [0:5];
        logic [DW-1:0] exp_d [0:5];
        int            exp_k [0:5];
        exp_a[0] = 15'd0;    exp_d[0] = RED;   exp_k[0] = 2;
        exp_a[1] = 15'd1;    exp_d[1] = RED;   exp_k[1] = 3;
        exp_a[2] = 15'd176;  exp_d[2] = RED;   exp_k[2] = 4;
        exp_a[3] = 15'd177;  exp_d[3] = RED;   exp_k[3] = 5;
        exp_a[4] = 15'd8900; exp_d[4] = GREEN; exp_k[4] = 9;
        exp_a[5] = 15'd9076; exp_d[5] = GREEN; exp_k[5] = 10;
        nwr        = 0;
        b_acc      = -1;
        ready_hi_a = 0;
        ndone      = 0;
        done_k[0]  = -1;
        done_k[1]  = -1;
        bus.req_x     = 8'd0;
        bus.req_y     = 7'd0;
        bus.req_w     = 8'd2;
        bus.req_h     = 7'd2;
        bus.req_color = RED;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_x = 8'd100;
        bus.req_y = 7'd50;
        bus.req_w = 8'd1;
        bus.req_h = 7'd2;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (b_acc > 0 && k == b_acc + 1) bus.req_valid = 1'b0;
            if (k <= 6 && bus.req_ready !== 1'b0) ready_hi_a++;
            if (bus.px_wr === 1'b1 && nwr < 128) begin
                wr_addr[nwr] = bus.mem_px_addr;
                wr_data[nwr] = bus.mem_px_data;
                wr_cyc[nwr]  = k;
                nwr++;
            end
            if (bus.done === 1'b1 && ndone < 2) begin
                done_k[ndone] = k;
                ndone++;
            end
            if (bus.req_ready === 1'b1 && bus.req_valid === 1'b1 && b_acc < 0) b_acc = k;
            if (ndone == 0) bus.req_color = k[0] ? BLUE : BLACK;
            else if (b_acc < 0) bus.req_color = GREEN;
        end
        vectors++;
        if (ready_hi_a != 0) begin
            miscompares++;
            $display("FAIL b2b_ready_low ready high in %0d of first-rect cycles, want 0", ready_hi_a);
        end
        vectors++;
        if (b_acc != 7) begin
            miscompares++;
            $display("FAIL b2b_accept second accepted at cycle %0d want 7", b_acc);
        end
        vectors++;
        if (nwr != 6) begin
            miscompares++;
            $display("FAIL b2b_count writes=%0d want 6", nwr);
        end
        for (int i = 0; i < 6 && i < nwr; i++) begin
            vectors++;
            if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i] || wr_cyc[i] != exp_k[i]) begin
                miscompares++;
                $display("FAIL b2b_px%0d addr=%0d data=%b cyc=%0d want %0d/%b/%0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i], exp_a[i], exp_d[i], exp_k[i]);
            end
        end
        vectors++;
        if (done_k[0] != 6 || done_k[1] != 11) begin
            miscompares++;
            $display("FAIL b2b_done done cycles %0d,%0d want 6,11", done_k[0], done_k[1]);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_w     = '0;
        bus.req_h     = '0;
        bus.req_color = '0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_basic();
        @(negedge clk);
        test_clip();
        @(negedge clk);
        test_zero_area();
        @(negedge clk);
        test_reset_mid();
        @(negedge clk);
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fb_rect_writer.md
# fb_rect_writer

Frame-buffer rectangle painter: accepts one rectangle request (origin, size, colour), clips it to the 176×120 playfield, and emits one pixel write per clock on a `buffer_ram_dp` write port (`addr_in`/`data_in`/`regwrite`). It drives the write end of the frame buffer whose read end is scanned by the VGA path. The game FSM uses it to draw paddles, ball, and clears without computing addresses itself.

## Interface
- `SCREEN_X`, 176, frame-buffer width in pixels
- `SCREEN_Y`, 120, frame-buffer height in pixels
- `AW`, 15, write-address width
- `DW`, 3, pixel width (RGB 111: bit2 R, bit1 G, bit0 B)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  rectangle request present
- `req_ready`  out  1  block idle, request accepted when `req_valid && req_ready`
- `req_x`  in  8  left column, 0..255
- `req_y`  in  7  top row, 0..127
- `req_w`  in  8  width in pixels
- `req_h`  in  7  height in pixels
- `req_color`  in  DW  fill colour
- `mem_px_addr`  out  AW  write address, `y*SCREEN_X + x`
- `mem_px_data`  out  DW  write data
- `px_wr`  out  1  write strobe, one pixel per cycle while high
- `busy`  out  1  high from acceptance until `done`, inclusive
- `done`  out  1  one-cycle pulse at rectangle completion

## Operation
- States: IDLE, SETUP, WRITE, DONE.
- IDLE: `req_ready`=1. On handshake, latch all `req_*` and go to SETUP. Request fields changing after acceptance have no effect.
- SETUP (1 cycle): compute the clipped extent.
  - `x_end = min(req_x+req_w, SCREEN_X)` and `y_end = min(req_y+req_h, SCREEN_Y)`, with 9-bit/8-bit intermediates so there is no wrap.
  - Zero area (`req_w`=0, `req_h`=0, `req_x>=SCREEN_X`, or `req_y>=SCREEN_Y`): go to DONE.
  - Otherwise load `row_base = req_y*SCREEN_X`, `col = req_x`, `row = req_y`, and go to WRITE.
- WRITE: each cycle, register `mem_px_addr = row_base + col`, `mem_px_data = color`, `px_wr = 1`.
  - Scan is row-major.
  - At `col = x_end-1`: reset `col` to `req_x`, set `row_base += SCREEN_X`, increment `row`.
  - After the last pixel (`row = y_end-1`, `col = x_end-1`) go to DONE.
- DONE: `done`=1 for one cycle, `px_wr`=0, then IDLE.
- No multiplier in the pixel loop. The only product is `req_y*SCREEN_X`, formed once in SETUP, and it may use a shift-add (176 = 128+32+16).
- Addresses never exceed `SCREEN_X*SCREEN_Y-1` = 21119.

## Timing
- Reset (`rst`=0 at a rising edge) sets, from the next cycle: `px_wr`=0, `done`=0, `busy`=0, `req_ready`=1, `mem_px_addr`=0, `mem_px_data`=0, state IDLE.
- Handshake at edge N. Cycle N+1 is SETUP: `req_ready`=0, `busy`=1, `px_wr`=0.
- First write is visible in cycle N+2. Writes occupy cycles N+2 .. N+1+cw·ch with no gaps, where cw and ch are the clipped width and height.
- `done`=1 in cycle N+2+cw·ch. `req_ready`=1 from cycle N+3+cw·ch.
- Zero area: `done` in cycle N+2, no `px_wr`.
- Back-to-back requests: minimum spacing is cw·ch+3 cycles. `req_valid` held high is accepted on the first cycle `req_ready` returns.
- Reset mid-rectangle: `px_wr` drops the next cycle and no `done` pulse occurs. Already-written pixels stay in memory.
- Write data and address change only together with `px_wr`. Outputs are registered, with no combinational path from `req_*` to the memory port.

## Structure
- Package `fb_pkg`:
  - `SCREEN_X`, `SCREEN_Y`, `AW`, `DW`
  - colour constants `RED`=3'b100, `GREEN`=3'b010, `BLUE`=3'b001, `BLACK`=3'b000
  - state encoding for IDLE/SETUP/WRITE/DONE
- One natural sub-module: `fb_rect_clip`, combinational, mapping latched x/y/w/h to `x_end`, `y_end`, `zero_area`. It is used in SETUP.
- The FSM and counters stay in `fb_rect_writer`.

## Test plan
- Reset: hold `rst`=0 two cycles → `px_wr`=0, `done`=0, `busy`=0, `req_ready`=1, `mem_px_addr`=0.
- Rectangle x=10, y=5, w=3, h=2, colour 3'b100:
  - Expect 6 consecutive writes at 890, 891, 892, 1066, 1067, 1068, all with data 3'b100.
  - Expect `done` one cycle after the last write, at N+8.
- Clip at the bottom-right corner, x=174, y=118, w=5, h=5 → exactly 4 writes at 20942, 20943, 21118, 21119, then `done`.
- Zero area with w=0, then separately x=176 → no `px_wr` and `done` at N+2.
- Reset mid-operation: 10×10 rectangle, drive `rst`=0 after 3 writes → `px_wr`=0 the next cycle, no `done`. After release, a new request is accepted normally.
- Back-to-back: hold `req_valid`=1 with two queued requests and toggle `req_color` during busy.
  - `req_ready` stays 0 throughout the first rectangle.
  - The first rectangle keeps its latched colour.
  - The second rectangle is accepted the cycle `req_ready` returns.
